// File: rtl/alpha2_3_gpio_pkg.sv
// Shared constants for the Wishbone GPIO / edge-interrupt block.
package alpha2_3_gpio_pkg;

  localparam int NPINS = 8;

  // Cycles after reset before edges may set status bits (synchronizer fill time).
  localparam logic [1:0] WARMUP_CYCLES = 2'd3;

  // Register word index taken from adr[4:2].
  typedef enum logic [2:0] {
    GPIO_DOUT    = 3'd0,
    GPIO_OE      = 3'd1,
    GPIO_DIN     = 3'd2,
    GPIO_RISE_EN = 3'd3,
    GPIO_FALL_EN = 3'd4,
    GPIO_RISE_ST = 3'd5,
    GPIO_FALL_ST = 3'd6,
    GPIO_RSVD    = 3'd7
  } gpio_reg_e;

endpackage

// File: rtl/alpha2_3_gpio_sync.sv
// Pad-input synchronizer and edge detector. Edges are held off until the
// synchronizer has filled after reset, so pins sitting high do not look like edges.
module alpha2_3_gpio_sync
  import alpha2_3_gpio_pkg::*;
#(
  parameter int WIDTH = NPINS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pins,
  output logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] s2;
  logic [WIDTH-1:0] s3;
  logic [1:0]       warm_cnt;
  logic             armed;

  assign armed = (warm_cnt == WARMUP_CYCLES);

  always_ff @(posedge clk) begin
    if (rst) begin
      s1       <= '0;
      s2       <= '0;
      s3       <= '0;
      warm_cnt <= '0;
    end else begin
      s1 <= pins;
      s2 <= s1;
      s3 <= s2;
      if (!armed) begin
        warm_cnt <= warm_cnt + 2'd1;
      end
    end
  end

  assign din  = s2;
  assign rise = armed ? (s2 & ~s3) : '0;
  assign fall = armed ? (~s2 & s3) : '0;

endmodule

// File: rtl/alpha2_3_wb_gpio_irq.sv
// Wishbone slave owning the low user IO pads: output data/enable, synchronized
// input, and sticky per-pin edge status with registered interrupt lines.
module alpha2_3_wb_gpio_irq #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int          NPINS     = 8
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             wbs_cyc_i,
  input  logic             wbs_stb_i,
  input  logic             wbs_we_i,
  input  logic [3:0]       wbs_sel_i,
  input  logic [31:0]      wbs_adr_i,
  input  logic [31:0]      wbs_dat_i,
  output logic             wbs_ack_o,
  output logic [31:0]      wbs_dat_o,
  input  logic [NPINS-1:0] io_in,
  output logic [NPINS-1:0] io_out,
  output logic [NPINS-1:0] io_oeb,
  output logic [2:0]       irq
);

  import alpha2_3_gpio_pkg::*;

  logic             req;
  logic             req_q;
  logic             ack_q;
  logic             access;
  logic             wr_en;
  gpio_reg_e        reg_sel;
  logic [NPINS-1:0] wdata;
  logic [NPINS-1:0] rd_data;
  logic [NPINS-1:0] dat_q;

  logic [NPINS-1:0] dout_q;
  logic [NPINS-1:0] oe_q;
  logic [NPINS-1:0] rise_en_q;
  logic [NPINS-1:0] fall_en_q;
  logic [NPINS-1:0] rise_st_q;
  logic [NPINS-1:0] fall_st_q;
  logic [NPINS-1:0] rise_clr;
  logic [NPINS-1:0] fall_clr;
  logic             rise_hit;
  logic             fall_hit;
  logic [2:0]       irq_q;

  logic [NPINS-1:0] din;
  logic [NPINS-1:0] rise;
  logic [NPINS-1:0] fall;

  logic unused_bits;
  assign unused_bits = ^{wbs_sel_i[3:1], wbs_adr_i[7:5], wbs_adr_i[1:0], wbs_dat_i[31:NPINS]};

  alpha2_3_gpio_sync #(
    .WIDTH(NPINS)
  ) u_sync (
    .clk  (wb_clk_i),
    .rst  (wb_rst_i),
    .pins (io_in),
    .din  (din),
    .rise (rise),
    .fall (fall)
  );

  // The request is registered once before it is acked; the live request must
  // still be present so a master that has already dropped stb is not acked again.
  assign req     = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
  assign access  = req & req_q & ~ack_q;
  assign reg_sel = gpio_reg_e'(wbs_adr_i[4:2]);
  assign wdata   = wbs_dat_i[NPINS-1:0];
  assign wr_en   = access & wbs_we_i & wbs_sel_i[0];

  assign rise_clr = (wr_en && reg_sel == GPIO_RISE_ST) ? wdata : '0;
  assign fall_clr = (wr_en && reg_sel == GPIO_FALL_ST) ? wdata : '0;

  assign rise_hit = |(rise_st_q & rise_en_q);
  assign fall_hit = |(fall_st_q & fall_en_q);

  always_comb begin
    rd_data = '0;
    case (reg_sel)
      GPIO_DOUT:    rd_data = dout_q;
      GPIO_OE:      rd_data = oe_q;
      GPIO_DIN:     rd_data = din;
      GPIO_RISE_EN: rd_data = rise_en_q;
      GPIO_FALL_EN: rd_data = fall_en_q;
      GPIO_RISE_ST: rd_data = rise_st_q;
      GPIO_FALL_ST: rd_data = fall_st_q;
      default:      rd_data = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      req_q     <= 1'b0;
      ack_q     <= 1'b0;
      dat_q     <= '0;
      dout_q    <= '0;
      oe_q      <= '0;
      rise_en_q <= '0;
      fall_en_q <= '0;
      rise_st_q <= '0;
      fall_st_q <= '0;
      irq_q     <= '0;
    end else begin
      req_q <= req;
      ack_q <= access;
      dat_q <= (access & ~wbs_we_i) ? rd_data : '0;

      if (wr_en) begin
        case (reg_sel)
          GPIO_DOUT:    dout_q    <= wdata;
          GPIO_OE:      oe_q      <= wdata;
          GPIO_RISE_EN: rise_en_q <= wdata;
          GPIO_FALL_EN: fall_en_q <= wdata;
          default:      ;
        endcase
      end

      // A new edge wins over a same-cycle write-one-to-clear.
      rise_st_q <= (rise_st_q & ~rise_clr) | rise;
      fall_st_q <= (fall_st_q & ~fall_clr) | fall;

      irq_q <= {rise_hit | fall_hit, fall_hit, rise_hit};
    end
  end

  assign wbs_ack_o = ack_q & ~wb_rst_i;
  assign wbs_dat_o = wbs_ack_o ? {{(32 - NPINS){1'b0}}, dat_q} : 32'd0;
  assign io_out    = dout_q;
  assign io_oeb    = ~oe_q;
  assign irq       = irq_q;

endmodule

// File: tb/tb_alpha2_3_wb_gpio_irq.sv
// Self-checking bench for the Wishbone GPIO / edge-interrupt block: directed
// timing scenarios plus a randomized run against a register-level model.
module tb_alpha2_3_wb_gpio_irq;

  localparam logic [31:0] BASE = 32'h3000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cyc = 1'b0;
  logic        stb = 1'b0;
  logic        we = 1'b0;
  logic [3:0]  sel = 4'h0;
  logic [31:0] adr = 32'h0;
  logic [31:0] wdat = 32'h0;
  logic        ack;
  logic [31:0] rdat;
  logic [7:0]  io_in = 8'h00;
  logic [7:0]  io_out;
  logic [7:0]  io_oeb;
  logic [2:0]  irq;

  int errors = 0;
  int checks = 0;

  // Register-level model state
  logic [7:0] m_dout, m_oe, m_ren, m_fen, m_rst_st, m_fst, m_pins;

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  alpha2_3_wb_gpio_irq #(
    .BASE_ADDR(BASE),
    .NPINS(8)
  ) dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .wbs_cyc_i (cyc),
    .wbs_stb_i (stb),
    .wbs_we_i  (we),
    .wbs_sel_i (sel),
    .wbs_adr_i (adr),
    .wbs_dat_i (wdat),
    .wbs_ack_o (ack),
    .wbs_dat_o (rdat),
    .io_in     (io_in),
    .io_out    (io_out),
    .io_oeb    (io_oeb),
    .irq       (irq)
  );

  task automatic bus_start(input logic [31:0] a, input logic w, input logic [7:0] d,
                           input logic [3:0] s);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = {24'h0, d}; sel = s;
  endtask

  task automatic bus_finish(input logic [7:0] off, output logic [31:0] data);
    logic got;
    int n;
    got = 1'b0; data = 32'h0; n = 0;
    while (!got && n < 8) begin
      @(negedge clk);
      n++;
      if (ack === 1'b1) begin
        got = 1'b1;
        data = rdat;
      end
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    checks++;
    if (got !== 1'b1) begin
      errors++;
      $display("FAIL bus_ack off=%h: no ack within 8 cycles, required ack", off);
    end
  endtask

  task automatic bus_write(input logic [7:0] off, input logic [7:0] d, input logic [3:0] s);
    logic [31:0] unused_data;
    bus_start(BASE + {24'h0, off}, 1'b1, d, s);
    bus_finish(off, unused_data);
  endtask

  task automatic bus_read(input logic [7:0] off, output logic [31:0] data);
    bus_start(BASE + {24'h0, off}, 1'b0, 8'h00, 4'hF);
    bus_finish(off, data);
  endtask

  function automatic logic [7:0] model_reg(input int idx);
    case (idx)
      0: return m_dout;
      1: return m_oe;
      2: return m_pins;
      3: return m_ren;
      4: return m_fen;
      5: return m_rst_st;
      6: return m_fst;
      default: return 8'h00;
    endcase
  endfunction

  task automatic test_reset();
    logic [31:0] d;
    rst = 1'b1; io_in = 8'hFF;
    repeat (4) @(negedge clk);
    checks++;
    if ({io_out, io_oeb, irq, ack, rdat} !== {8'h00, 8'hFF, 3'b000, 1'b0, 32'h0}) begin
      errors++;
      $display("FAIL reset_hold: out=%h oeb=%h irq=%b ack=%b dat=%h, required 00 ff 000 0 0",
               io_out, io_oeb, irq, ack, rdat);
    end
    rst = 1'b0;
    repeat (10) @(negedge clk);
    checks++;
    if ({io_out, io_oeb, irq} !== {8'h00, 8'hFF, 3'b000}) begin
      errors++;
      $display("FAIL reset_release: out=%h oeb=%h irq=%b, required 00 ff 000", io_out, io_oeb, irq);
    end
    bus_read(8'h14, d);
    checks++;
    if (d !== 32'h0) begin
      errors++;
      $display("FAIL reset_rise_st: got %h, required 0 (no spurious edge)", d);
    end
    bus_read(8'h08, d);
    checks++;
    if (d !== 32'hFF) begin
      errors++;
      $display("FAIL reset_din: got %h, required ff", d);
    end
  endtask

  task automatic test_write_readback();
    logic [31:0] d;
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = BASE; wdat = 32'hA5; sel = 4'hF;
    @(negedge clk);
    checks++;
    if ({ack, io_out} !== {1'b0, 8'h00}) begin
      errors++;
      $display("FAIL wr_early: ack=%b out=%h, required 0 00", ack, io_out);
    end
    @(negedge clk);
    checks++;
    if ({ack, io_out} !== {1'b1, 8'hA5}) begin
      errors++;
      $display("FAIL wr_ack_cycle: ack=%b out=%h, required 1 a5", ack, io_out);
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(negedge clk);
    checks++;
    if (ack !== 1'b0) begin
      errors++;
      $display("FAIL ack_one_cycle: ack=%b, required 0", ack);
    end
    bus_write(8'h04, 8'h0F, 4'hF);
    checks++;
    if (io_oeb !== 8'hF0) begin
      errors++;
      $display("FAIL oe_ack_cycle: oeb=%h, required f0", io_oeb);
    end
    bus_read(8'h00, d);
    checks++;
    if (d !== 32'hA5) begin
      errors++;
      $display("FAIL rd_dout: got %h, required a5", d);
    end
    bus_read(8'h04, d);
    checks++;
    if (d !== 32'h0F) begin
      errors++;
      $display("FAIL rd_oe: got %h, required 0f", d);
    end
    bus_write(8'h00, 8'h5A, 4'b0010);
    bus_read(8'h00, d);
    checks++;
    if (d !== 32'hA5 || io_out !== 8'hA5) begin
      errors++;
      $display("FAIL sel_ignored: reg=%h out=%h, required a5 a5", d, io_out);
    end
  endtask

  task automatic test_rise_irq();
    logic [31:0] d;
    @(negedge clk); io_in = 8'h00;
    repeat (6) @(negedge clk);
    bus_write(8'h18, 8'hFF, 4'hF);
    bus_write(8'h14, 8'hFF, 4'hF);
    bus_write(8'h0C, 8'h01, 4'hF);
    repeat (3) @(negedge clk);
    checks++;
    if (irq !== 3'b000) begin
      errors++;
      $display("FAIL rise_idle: irq=%b, required 000", irq);
    end
    io_in[0] = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (irq !== 3'b000) begin
      errors++;
      $display("FAIL rise_irq_early: irq=%b at k+2, required 000", irq);
    end
    @(negedge clk);
    checks++;
    if (irq !== 3'b101) begin
      errors++;
      $display("FAIL rise_irq: irq=%b at k+3, required 101", irq);
    end
    bus_read(8'h14, d);
    checks++;
    if (d !== 32'h01) begin
      errors++;
      $display("FAIL rise_st: got %h, required 01", d);
    end
    bus_write(8'h14, 8'h01, 4'hF);
    checks++;
    if (irq !== 3'b101) begin
      errors++;
      $display("FAIL w1c_irq_hold: irq=%b on ack cycle, required 101", irq);
    end
    @(negedge clk);
    checks++;
    if (irq !== 3'b000) begin
      errors++;
      $display("FAIL w1c_irq_clear: irq=%b, required 000", irq);
    end
  endtask

  task automatic test_collision();
    logic [31:0] d;
    bus_write(8'h10, 8'h08, 4'hF);
    @(negedge clk); io_in[3] = 1'b1;
    repeat (5) @(negedge clk);
    io_in[3] = 1'b0;
    repeat (5) @(negedge clk);
    io_in[3] = 1'b1;
    repeat (5) @(negedge clk);
    // Fall sampled at edge k sets status at k+2, which is the W1C's ack edge.
    io_in[3] = 1'b0;
    bus_start(BASE + 32'h18, 1'b1, 8'h08, 4'hF);
    bus_finish(8'h18, d);
    repeat (2) @(negedge clk);
    bus_read(8'h18, d);
    checks++;
    if (d !== 32'h08) begin
      errors++;
      $display("FAIL collision_fall_st: got %h, required 08", d);
    end
    checks++;
    if (irq !== 3'b110) begin
      errors++;
      $display("FAIL collision_irq: irq=%b, required 110", irq);
    end
    bus_write(8'h18, 8'h08, 4'hF);
    repeat (2) @(negedge clk);
    bus_read(8'h18, d);
    checks++;
    if (d !== 32'h00 || irq !== 3'b000) begin
      errors++;
      $display("FAIL fall_w1c: st=%h irq=%b, required 00 000", d, irq);
    end
  endtask

  task automatic test_decode();
    logic [31:0] d;
    logic got, bad_dat;
    got = 1'b0; bad_dat = 1'b0;
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h3000_0100; wdat = 32'hFF; sel = 4'hF;
    repeat (8) begin
      @(negedge clk);
      if (ack !== 1'b0) got = 1'b1;
      if (rdat !== 32'h0) bad_dat = 1'b1;
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    checks++;
    if (got !== 1'b0 || bad_dat !== 1'b0) begin
      errors++;
      $display("FAIL decode_outside: ack_seen=%b dat_nonzero=%b, required 0 0", got, bad_dat);
    end
    checks++;
    if (io_out !== 8'hA5) begin
      errors++;
      $display("FAIL decode_outside_effect: out=%h, required a5", io_out);
    end
    bus_write(8'h1C, 8'hFF, 4'hF);
    bus_read(8'h1C, d);
    checks++;
    if (d !== 32'h0) begin
      errors++;
      $display("FAIL decode_rsvd: got %h, required 0", d);
    end
  endtask

  task automatic test_back_to_back();
    int acks;
    logic prev, consec, bad_dat;
    acks = 0; prev = 1'b0; consec = 1'b0; bad_dat = 1'b0;
    bus_start(BASE, 1'b0, 8'h00, 4'hF);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (ack === 1'b1) begin
        acks++;
        if (prev) consec = 1'b1;
        if (rdat !== 32'hA5) bad_dat = 1'b1;
      end else if (rdat !== 32'h0) begin
        bad_dat = 1'b1;
      end
      prev = ack;
    end
    cyc = 1'b0; stb = 1'b0;
    checks++;
    if (acks != 5 || consec || bad_dat) begin
      errors++;
      $display("FAIL back_to_back: acks=%0d consecutive=%b bad_dat=%b, required 5 0 0",
               acks, consec, bad_dat);
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [31:0] d;
    logic [7:0]  v, p;
    logic [3:0]  s;
    logic        which, r, f;
    int          idx;
    m_dout = 8'($urandom); m_oe = 8'($urandom); m_ren = 8'h00; m_fen = 8'h00;
    bus_write(8'h00, m_dout, 4'hF);
    bus_write(8'h04, m_oe, 4'hF);
    bus_write(8'h0C, 8'h00, 4'hF);
    bus_write(8'h10, 8'h00, 4'hF);
    bus_write(8'h14, 8'hFF, 4'hF);
    bus_write(8'h18, 8'hFF, 4'hF);
    m_rst_st = 8'h00; m_fst = 8'h00; m_pins = io_in;
    for (int it = 0; it < 40; it++) begin
      which = 1'($urandom_range(0, 1));
      v = 8'($urandom);
      case ($urandom_range(0, 3))
        0: begin
          p = 8'($urandom);
          @(negedge clk); io_in = p;
          m_rst_st = m_rst_st | (p & ~m_pins);
          m_fst    = m_fst | (~p & m_pins);
          m_pins   = p;
          repeat (4) @(negedge clk);
        end
        1: begin
          bus_write(which ? 8'h10 : 8'h0C, v, 4'h1);
          if (which) m_fen = v; else m_ren = v;
        end
        2: begin
          bus_write(which ? 8'h18 : 8'h14, v, 4'hF);
          if (which) m_fst = m_fst & ~v; else m_rst_st = m_rst_st & ~v;
        end
        default: begin
          s = 4'($urandom_range(0, 15));
          bus_write(which ? 8'h04 : 8'h00, v, s);
          if (s[0]) begin
            if (which) m_oe = v; else m_dout = v;
          end
          checks++;
          if (io_out !== m_dout || io_oeb !== ~m_oe) begin
            errors++;
            $display("FAIL rand_pads it=%0d: out=%h oeb=%h, required %h %h",
                     it, io_out, io_oeb, m_dout, ~m_oe);
          end
        end
      endcase
      repeat (2) @(negedge clk);
      r = |(m_rst_st & m_ren);
      f = |(m_fst & m_fen);
      checks++;
      if (irq !== {r | f, f, r}) begin
        errors++;
        $display("FAIL rand_irq it=%0d: irq=%b, required %b", it, irq, {r | f, f, r});
      end
      idx = $urandom_range(0, 7);
      bus_read(8'(idx * 4), d);
      checks++;
      if (d !== {24'h0, model_reg(idx)}) begin
        errors++;
        $display("FAIL rand_read it=%0d reg=%0d: got %h, required %h", it, idx, d, model_reg(idx));
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    bus_write(8'h00, 8'h3C, 4'hF);
    bus_write(8'h04, 8'hFF, 4'hF);
    bus_start(BASE, 1'b0, 8'h00, 4'hF);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({ack, rdat, io_out, io_oeb, irq} !== {1'b0, 32'h0, 8'h00, 8'hFF, 3'b000}) begin
      errors++;
      $display("FAIL rst_mid: ack=%b dat=%h out=%h oeb=%h irq=%b, required 0 0 00 ff 000",
               ack, rdat, io_out, io_oeb, irq);
    end
    cyc = 1'b0; stb = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    bus_read(8'h00, d);
    checks++;
    if (d !== 32'h0) begin
      errors++;
      $display("FAIL rst_mid_dout: got %h, required 0", d);
    end
    bus_write(8'h00, 8'h77, 4'hF);
    bus_start(BASE, 1'b0, 8'h00, 4'hF);
    repeat (2) @(negedge clk);
    checks++;
    if (ack !== 1'b1) begin
      errors++;
      $display("FAIL rst_b_ack: ack=%b, required 1", ack);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (ack !== 1'b0 || rdat !== 32'h0) begin
      errors++;
      $display("FAIL rst_same_cycle: ack=%b dat=%h, required 0 0", ack, rdat);
    end
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0;
    checks++;
    if (io_out !== 8'h00 || io_oeb !== 8'hFF) begin
      errors++;
      $display("FAIL rst_b_pads: out=%h oeb=%h, required 00 ff", io_out, io_oeb);
    end
    rst = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_write_readback();
    test_rise_irq();
    test_collision();
    test_decode();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
